i2c_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one byte-level I2C master engine among `N` on-chip requesters. It accepts one-byte read/write requests, grants the master to one requester at a time, and issues a start pulse. It watches for completion, aborts the master after `TIMEOUT` cycles without completion, and returns the status and read data to the granted requester. The block sits between the requesters and the I2C master, which owns `sclk`/`sda`.

---
 rtl/i2c_arbiter.sv | 161 ++++++++++++++++
 tb/tb_i2c_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter and transaction sequencer for a shared I2C byte master
module i2c_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     req_rw,
  input  logic [8*N-1:0]   req_wdata,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     req_done,
  output logic             req_err,
  output logic [7:0]       rdata,
  output logic             busy,
  output logic             m_start,
  output logic             m_rw,
  output logic [7:0]       m_wdata,
  output logic             m_abort,
  input  logic             m_busy,
  input  logic             m_done,
  input  logic             m_nack,
  input  logic [7:0]       m_rdata
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [15:0]   r_timer, w_timer_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic [N-1:0]  r_req_done, w_req_done_nxt;
  logic          r_req_err, w_req_err_nxt;
  logic [7:0]    r_rdata, w_rdata_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_m_start, w_m_start_nxt;
  logic          r_m_rw, w_m_rw_nxt;
  logic [7:0]    r_m_wdata, w_m_wdata_nxt;
  logic          r_m_abort, w_m_abort_nxt;

  logic          w_found;
  logic [IW-1:0] w_win;
  int            w_k;

  // Search starts just after the last winner so it drops to lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_k     = 0;
    for (int i = 1; i <= N; i++) begin
      w_k = (int'(r_ptr) + i) % N;
      if (!w_found && req[w_k[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_k[IW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_idx_nxt      = r_idx;
    w_timer_nxt    = r_timer;
    w_gnt_nxt      = r_gnt;
    w_req_done_nxt = '0;
    w_req_err_nxt  = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_m_start_nxt  = 1'b0;
    w_m_rw_nxt     = r_m_rw;
    w_m_wdata_nxt  = r_m_wdata;
    w_m_abort_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !m_busy) begin
          w_gnt_nxt        = '0;
          w_gnt_nxt[w_win] = 1'b1;
          w_idx_nxt        = w_win;
          w_m_rw_nxt       = req_rw[w_win];
          w_m_wdata_nxt    = req_wdata[8*w_win +: 8];
          w_m_start_nxt    = 1'b1;
          w_timer_nxt      = '0;
          w_state_nxt      = S_WAIT;
        end
      end
      S_WAIT: begin
        w_timer_nxt = r_timer + 16'd1;
        // Completion takes precedence over a timeout in the same cycle.
        if (m_done) begin
          w_rdata_nxt           = m_rdata;
          w_req_err_nxt         = m_nack;
          w_req_done_nxt[r_idx] = 1'b1;
          w_state_nxt           = S_DONE;
        end else if (r_timer == 16'(TIMEOUT - 1)) begin
          w_m_abort_nxt = 1'b1;
          w_state_nxt   = S_ABORT;
        end
      end
      S_ABORT: begin
        if (!m_busy || m_done) begin
          w_rdata_nxt           = 8'h00;
          w_req_err_nxt         = 1'b1;
          w_req_done_nxt[r_idx] = 1'b1;
          w_state_nxt           = S_DONE;
        end
      end
      S_DONE: begin
        w_gnt_nxt   = '0;
        w_ptr_nxt   = r_idx;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= IW'(N - 1);
      r_idx      <= '0;
      r_timer    <= '0;
      r_gnt      <= '0;
      r_req_done <= '0;
      r_req_err  <= 1'b0;
      r_rdata    <= 8'h00;
      r_busy     <= 1'b0;
      r_m_start  <= 1'b0;
      r_m_rw     <= 1'b0;
      r_m_wdata  <= 8'h00;
      r_m_abort  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_idx      <= w_idx_nxt;
      r_timer    <= w_timer_nxt;
      r_gnt      <= w_gnt_nxt;
      r_req_done <= w_req_done_nxt;
      r_req_err  <= w_req_err_nxt;
      r_rdata    <= w_rdata_nxt;
      r_busy     <= w_busy_nxt;
      r_m_start  <= w_m_start_nxt;
      r_m_rw     <= w_m_rw_nxt;
      r_m_wdata  <= w_m_wdata_nxt;
      r_m_abort  <= w_m_abort_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign req_done = r_req_done;
  assign req_err  = r_req_err;
  assign rdata    = r_rdata;
  assign busy     = r_busy;
  assign m_start  = r_m_start;
  assign m_rw     = r_m_rw;
  assign m_wdata  = r_m_wdata;
  assign m_abort  = r_m_abort;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed self-checking bench for i2c_arbiter
module tb_i2c_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_rw;
  logic [31:0] req_wdata;
  logic [3:0]  gnt, req_done;
  logic        req_err, busy, m_start, m_rw, m_abort;
  logic [7:0]  rdata, m_wdata, m_rdata;
  logic        m_busy, m_done, m_nack;

  int checks = 0;
  int errors = 0;

  i2c_arbiter #(.N(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_wdata(req_wdata),
    .gnt(gnt), .req_done(req_done), .req_err(req_err), .rdata(rdata), .busy(busy),
    .m_start(m_start), .m_rw(m_rw), .m_wdata(m_wdata), .m_abort(m_abort),
    .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Master raises m_done `delay` cycles after the m_start cycle; returns in the req_done cycle.
  task automatic master_complete(input int delay, input logic nack, input logic [7:0] rd);
    repeat (delay) tick();
    m_done = 1'b1; m_nack = nack; m_rdata = rd;
    tick();
    m_done = 1'b0; m_nack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; req_rw = '0; req_wdata = 32'h0; m_busy = 0; m_done = 0; m_nack = 0; m_rdata = 8'h00;
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    checks++; if ({busy, m_start, m_abort, m_rw, req_err} !== 5'b0) begin errors++; $display("FAIL rst_ctl got=%b exp=00000", {busy, m_start, m_abort, m_rw, req_err}); end
    checks++; if ({req_done, rdata, m_wdata} !== 20'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", {req_done, rdata, m_wdata}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    req_wdata = 32'h11A52233; req_rw = 4'b0000; req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wr_gnt got=%b exp=0100", gnt); end
    checks++; if (m_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wr_start got=%b%b exp=11", m_start, busy); end
    checks++; if (m_wdata !== 8'hA5 || m_rw !== 1'b0) begin errors++; $display("FAIL wr_data got=%h/%b exp=a5/0", m_wdata, m_rw); end
    req_wdata = 32'hFFFFFFFF;
    tick();
    checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL wr_start_pulse got=%b exp=0", m_start); end
    checks++; if (m_wdata !== 8'hA5) begin errors++; $display("FAIL wr_data_hold got=%h exp=a5", m_wdata); end
    master_complete(9, 1'b0, 8'h77);
    checks++; if (req_done !== 4'b0100 || req_err !== 1'b0) begin errors++; $display("FAIL wr_done got=%b/%b exp=0100/0", req_done, req_err); end
    tick();
    req = 4'b0000;
    checks++; if (req_done !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL wr_idle got=%b/%b/%b exp=0000/0000/0", req_done, gnt, busy); end
    tick();
  endtask

  task automatic test_read();
    req_rw = 4'b0010; req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010 || m_rw !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%b/%b exp=0010/1", gnt, m_rw); end
    master_complete(3, 1'b0, 8'h3C);
    checks++; if (req_done !== 4'b0010 || rdata !== 8'h3C || req_err !== 1'b0) begin errors++; $display("FAIL rd_done got=%b/%h/%b exp=0010/3c/0", req_done, rdata, req_err); end
    tick();
    req = 4'b0000; req_rw = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    int         exp_rr[6];
    logic [3:0] e;
    exp_rr = '{0, 1, 2, 3, 0, 1};
    rst = 1'b0;
    tick();
    rst = 1'b1; req = 4'b1111;
    tick();
    for (int i = 0; i < 6; i++) begin
      e = 4'b0001 << exp_rr[i];
      checks++; if (gnt !== e || m_start !== 1'b1) begin errors++; $display("FAIL rr_gnt%0d got=%b/%b exp=%b/1", i, gnt, m_start, e); end
      master_complete(5, 1'b0, 8'(i));
      checks++; if (req_done !== e) begin errors++; $display("FAIL rr_done%0d got=%b exp=%b", i, req_done, e); end
      tick();
      checks++; if (gnt !== 4'b0000 || req_done !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d got=%b/%b exp=0000/0000", i, gnt, req_done); end
      if (i == 5) req = 4'b0000;
      tick();
    end
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rr_end got=%b/%b exp=0000/0", gnt, busy); end
  endtask

  task automatic test_nack();
    req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL nack_gnt got=%b exp=1000", gnt); end
    master_complete(2, 1'b1, 8'hFF);
    checks++; if (req_done !== 4'b1000 || req_err !== 1'b1) begin errors++; $display("FAIL nack_done got=%b/%b exp=1000/1", req_done, req_err); end
    tick();
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL nack_next_gnt got=%b exp=0001", gnt); end
    master_complete(2, 1'b0, 8'h11);
    checks++; if (req_done !== 4'b0001 || req_err !== 1'b0 || rdata !== 8'h11) begin errors++; $display("FAIL nack_next_done got=%b/%b/%h exp=0001/0/11", req_done, req_err, rdata); end
    tick();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    int early;
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001 || m_start !== 1'b1) begin errors++; $display("FAIL to_gnt got=%b/%b exp=0001/1", gnt, m_start); end
    m_busy = 1'b1;
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (m_abort !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL to_early_abort got=%0d exp=0", early); end
    tick();
    checks++; if (m_abort !== 1'b1) begin errors++; $display("FAIL to_abort got=%b exp=1", m_abort); end
    tick();
    checks++; if (m_abort !== 1'b0 || req_done !== 4'b0000) begin errors++; $display("FAIL to_abort_pulse got=%b/%b exp=0/0000", m_abort, req_done); end
    tick(); tick();
    m_busy = 1'b0;
    tick();
    checks++; if (req_done !== 4'b0001 || req_err !== 1'b1 || rdata !== 8'h00) begin errors++; $display("FAIL to_done got=%b/%b/%h exp=0001/1/00", req_done, req_err, rdata); end
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to2_gnt got=%b exp=0010", gnt); end
    m_busy = 1'b1;
    repeat (14) tick();
    m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'h5A;
    tick();
    m_done = 1'b0; m_busy = 1'b0;
    checks++; if (m_abort !== 1'b0) begin errors++; $display("FAIL to2_no_abort got=%b exp=0", m_abort); end
    checks++; if (req_done !== 4'b0010 || req_err !== 1'b0 || rdata !== 8'h5A) begin errors++; $display("FAIL to2_done got=%b/%b/%h exp=0010/0/5a", req_done, req_err, rdata); end
    tick();
    checks++; if (m_abort !== 1'b0) begin errors++; $display("FAIL to2_no_abort_late got=%b exp=0", m_abort); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    req_wdata = 32'hC3000000; req = 4'b1001;
    tick();
    checks++; if (gnt !== 4'b1000 || m_wdata !== 8'hC3) begin errors++; $display("FAIL rmw_gnt got=%b/%h exp=1000/c3", gnt, m_wdata); end
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if ({gnt, req_done} !== 8'h00 || {busy, m_start, m_abort, m_rw} !== 4'b0) begin errors++; $display("FAIL rmw_clear got=%b/%b/%b exp=0", gnt, req_done, {busy, m_start, m_abort, m_rw}); end
    checks++; if (m_wdata !== 8'h00 || rdata !== 8'h00) begin errors++; $display("FAIL rmw_data got=%h/%h exp=00/00", m_wdata, rdata); end
    tick();
    checks++; if (gnt !== 4'b0001 || req_done !== 4'b0000) begin errors++; $display("FAIL rmw_regnt got=%b/%b exp=0001/0000", gnt, req_done); end
    master_complete(1, 1'b0, 8'h99);
    checks++; if (req_done !== 4'b0001 || rdata !== 8'h99) begin errors++; $display("FAIL rmw_done got=%b/%h exp=0001/99", req_done, rdata); end
    tick();
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_round_robin();
    test_nack();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
